// File: rtl/pwm_multichannel.sv
// N-channel PWM generator: shared prescaler, edge/center-aligned counter, shadowed duty registers.
// Optional PWM_POLARITY_EN macro adds a per-channel output polarity input pol_i.
module pwm_multichannel #(
  parameter int NUM_CH  = 16,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  en_out_i,
  input  logic [NUM_CH-1:0]  en_pwm_i,
  input  logic               wr_en_i,
  input  logic [3:0]         wr_ch_i,
  input  logic [DUTY_W-1:0]  wr_duty_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               center_mode_i,
`ifdef PWM_POLARITY_EN
  input  logic [NUM_CH-1:0]  pol_i,
`endif
  output logic [NUM_CH-1:0]  out_o,
  output logic               period_start_o
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;

  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [PRESC_W-1:0]             presc_cnt_q, presc_cnt_d;
  logic [DUTY_W-1:0]              cnt_q, cnt_d;
  dir_e                           dir_q, dir_d;
  mode_e                          mode_q, mode_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]  active_q, active_d;
  logic [NUM_CH-1:0]              out_q, out_d;
  logic                           period_start_q;
  logic                           tick;
  logic                           boundary;
  logic                           cmp;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    out_d       = '0;
    boundary    = 1'b0;
    cmp         = 1'b0;

    // >= rather than == so lowering prescale below the running count ticks at once.
    tick = (presc_cnt_q >= prescale_i);
    if (tick) presc_cnt_d = '0;

    if (tick) begin
      if (mode_q == MODE_EDGE) begin
        cnt_d    = cnt_q + DUTY_W'(1);
        boundary = (cnt_q == CNT_MAX);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == CNT_MAX) dir_d = DIR_DOWN;
        else                  cnt_d = cnt_q + DUTY_W'(1);
      end else begin
        if (cnt_q == '0) begin
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - DUTY_W'(1);
        end
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en_i && (wr_ch_i == 4'(i))) shadow_d[i] = wr_duty_i;
    end

    // Loading from shadow_d lets a write on the boundary cycle reach the new period.
    if (boundary) begin
      active_d = shadow_d;
      mode_d   = mode_e'(center_mode_i);
      dir_d    = DIR_UP;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      cmp = en_pwm_i[i] ? ((active_q[i] == CNT_MAX) || (cnt_q < active_q[i])) : 1'b1;
`ifdef PWM_POLARITY_EN
      cmp = cmp ^ pol_i[i];
`endif
      out_d[i] = en_out_i[i] & cmp;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments; the duty register arrays are reset
    // too, so a restart never drives stale duty values.
    if (!rst_n) begin
      presc_cnt_q    <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      mode_q         <= MODE_EDGE;
      shadow_q       <= '0;
      active_q       <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      out_q          <= out_d;
      period_start_q <= boundary;
    end
  end

  assign out_o          = out_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: directed scenarios plus randomized traffic,
// compared every cycle against a period-position reference model.
module tb_pwm_multichannel;

  localparam int NUM_CH  = 8;
  localparam int DUTY_W  = 8;
  localparam int PRESC_W = 8;
  localparam int SPAN    = 1 << DUTY_W;

  logic               clk;
  logic               rst_n;
  logic [NUM_CH-1:0]  en_out;
  logic [NUM_CH-1:0]  en_pwm;
  logic               wr_en;
  logic [3:0]         wr_ch;
  logic [DUTY_W-1:0]  wr_duty;
  logic [PRESC_W-1:0] prescale;
  logic               center_mode;
  logic [NUM_CH-1:0]  pol;
  logic [NUM_CH-1:0]  out;
  logic               period_start;

  pwm_multichannel #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_out_i      (en_out),
    .en_pwm_i      (en_pwm),
    .wr_en_i       (wr_en),
    .wr_ch_i       (wr_ch),
    .wr_duty_i     (wr_duty),
    .prescale_i    (prescale),
    .center_mode_i (center_mode),
`ifdef PWM_POLARITY_EN
    .pol_i         (pol),
`endif
    .out_o         (out),
    .period_start_o(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the period in ticks, from which cnt follows directly.
  int               m_pcnt;
  int               m_pos;
  bit               m_center;
  int               m_shadow [NUM_CH];
  int               m_active [NUM_CH];
  logic [NUM_CH-1:0] m_out;
  logic             m_ps;
  int               hi_cnt [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int  plen, cnt, duty;
    bit  tick, bnd, v;
    if (!rst_n) begin
      m_pcnt = 0; m_pos = 0; m_center = 0; m_out = '0; m_ps = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_shadow[c] = 0; m_active[c] = 0; end
    end else begin
      plen = m_center ? 2 * SPAN : SPAN;
      cnt  = (m_pos < SPAN) ? m_pos : (2 * SPAN - 1 - m_pos);
      for (int c = 0; c < NUM_CH; c++) begin
        duty = m_active[c];
        if (!en_out[c])      v = 0;
        else begin
          if (!en_pwm[c])    v = 1;
          else               v = (duty == SPAN - 1) || (cnt < duty);
`ifdef PWM_POLARITY_EN
          v = v ^ pol[c];
`endif
        end
        m_out[c] = v;
      end
      tick   = (m_pcnt >= int'(prescale));
      m_pcnt = tick ? 0 : m_pcnt + 1;
      bnd    = tick && (m_pos == plen - 1);
      if (wr_en && int'(wr_ch) < NUM_CH) m_shadow[wr_ch] = int'(wr_duty);
      if (tick) m_pos = bnd ? 0 : m_pos + 1;
      if (bnd) begin
        for (int c = 0; c < NUM_CH; c++) m_active[c] = m_shadow[c];
        m_center = center_mode;
      end
      m_ps = bnd;
    end
    @(posedge clk);
    #1;
    check("model_out", 32'(out), 32'(m_out));
    check("model_period_start", 32'(period_start), 32'(m_ps));
  endtask

  task automatic do_write(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = ch[3:0];
    wr_duty = duty[DUTY_W-1:0];
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string tag, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < bound);
    check(tag, 32'(period_start), 32'd1);
  endtask

  task automatic count_high(input int n);
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    repeat (n) begin
      step();
      for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(out[c]);
    end
  endtask

  initial begin
    int n, hi, ps_cnt, last, gap;

    rst_n = 1'b0; en_out = '0; en_pwm = '0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    prescale = '0; center_mode = 1'b0; pol = '0;
    repeat (3) step();
    check("reset_out", 32'(out), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);
    rst_n = 1'b1;

    // Idle: outputs disabled, period_start every 256 clocks.
    hi = 0; ps_cnt = 0; last = -1; gap = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (out != '0) hi++;
      if (period_start) begin
        ps_cnt++;
        if (last >= 0) gap = i - last;
        last = i;
      end
    end
    check("idle_out_high", 32'(hi), 32'd0);
    check("idle_ps_count", 32'(ps_cnt), 32'd3);
    check("idle_ps_gap", 32'(gap), 32'd256);

    // Edge mode, 50% duty on ch0.
    en_out = 8'h01; en_pwm = 8'h01;
    do_write(0, 'h80);
    wait_ps("edge50_ps", 600, n);
    count_high(SPAN);
    check("edge50_high", 32'(hi_cnt[0]), 32'd128);
    count_high(SPAN);
    check("edge50_repeat", 32'(hi_cnt[0]), 32'd128);

    // Duty extremes and static mode.
    do_write(1, 'h00); do_write(2, 'hFF); do_write(4, 'h10);
    en_out = 8'h17; en_pwm = 8'h07;
    wait_ps("extreme_ps", 600, n);
    count_high(SPAN);
    check("duty00_high", 32'(hi_cnt[1]), 32'd0);
    check("dutyFF_high", 32'(hi_cnt[2]), 32'd256);
    check("static_high", 32'(hi_cnt[4]), 32'd256);

    // Shadow update on ch3: mid-period write, then a write on the boundary cycle.
    do_write(3, 'h20);
    en_out = 8'h1F; en_pwm = 8'h0F;
    wait_ps("shadow_load_ps", 600, n);
    wait_ps("shadow_start_ps", 600, n);
    hi = 0;
    for (int s = 0; s < SPAN; s++) begin
      if (s == 100) begin wr_en = 1'b1; wr_ch = 4'd3; wr_duty = 8'h40; end
      step();
      wr_en = 1'b0;
      hi += int'(out[3]);
    end
    check("shadow_cur_period", 32'(hi), 32'd32);
    check("shadow_ps_aligned1", 32'(period_start), 32'd1);
    hi = 0;
    for (int s = 0; s < SPAN; s++) begin
      if (s == SPAN - 1) begin wr_en = 1'b1; wr_ch = 4'd3; wr_duty = 8'h60; end
      step();
      wr_en = 1'b0;
      hi += int'(out[3]);
    end
    check("shadow_next_period", 32'(hi), 32'd64);
    check("shadow_ps_aligned2", 32'(period_start), 32'd1);
    count_high(SPAN);
    check("boundary_write_same_period", 32'(hi_cnt[3]), 32'd96);

    // Center mode with prescale=3 on ch1.
    do_write(1, 'h10);
    repeat (50) step();
    prescale = 8'd3;
    center_mode = 1'b1;
    wait_ps("center_latch_ps", 2000, n);
    n = 0; hi = 0;
    do begin
      step(); n++; hi += int'(out[1]);
    end while (period_start !== 1'b1 && n < 3000);
    check("center_period", 32'(n), 32'd2048);
    check("center_high", 32'(hi), 32'd128);
    repeat (500) step();
    center_mode = 1'b0;
    wait_ps("center_tail_ps", 3000, n);
    check("mode_change_deferred", 32'(n + 500), 32'd2048);
    wait_ps("edge_presc3_ps", 3000, n);
    check("edge_presc3_period", 32'(n), 32'd1024);

    // Out-of-range channel write is ignored.
    prescale = 8'd0;
    do_write(15, 'hFF);
    wait_ps("ignore_ps1", 3000, n);
    wait_ps("ignore_ps2", 3000, n);
    count_high(SPAN);
    check("ignore_ch0", 32'(hi_cnt[0]), 32'd128);
    check("ignore_ch1", 32'(hi_cnt[1]), 32'd16);
    check("ignore_ch3", 32'(hi_cnt[3]), 32'd96);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        wr_en = 1'b1; wr_ch = 4'($urandom_range(0, 15)); wr_duty = 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        en_out = NUM_CH'($urandom); en_pwm = NUM_CH'($urandom); pol = NUM_CH'($urandom);
      end
      if ($urandom_range(0, 299) == 0) prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) center_mode = ~center_mode;
      step();
      wr_en = 1'b0;
    end

    // Reset asserted while ch0 is high.
    prescale = 8'd0; center_mode = 1'b0; pol = '0;
    en_out = 8'h01; en_pwm = 8'h01;
    do_write(0, 'h80);
    wait_ps("prereset_ps1", 3000, n);
    wait_ps("prereset_ps2", 3000, n);
    repeat (10) step();
    check("prereset_high", 32'(out[0]), 32'd1);
    rst_n = 1'b0;
    step();
    check("midreset_out", 32'(out), 32'd0);
    check("midreset_ps", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    n = 0; hi = 0;
    do begin
      step(); n++; hi += int'(out[0]);
    end while (period_start !== 1'b1 && n < 600);
    check("restart_period", 32'(n), 32'd256);
    check("restart_no_pulse", 32'(hi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
Parametrised N-channel PWM generator with an independent duty register per channel, a shared clock prescaler and edge- or center-aligned counting. Duty writes land in per-channel shadow registers and are applied only at a period boundary, so a duty change never produces a glitch. The block sits under the chip top level, and its out bus drives the dedicated and bidirectional output pins.

Parameters:
NUM_CH, 16, number of PWM channels (1..16)
DUTY_W, 8, counter and duty width in bits
PRESC_W, 8, prescaler width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en_out  in  NUM_CH  per-channel output enable; 0 forces the output low
en_pwm  in  NUM_CH  per-channel mode; 1 = PWM, 0 = static high when enabled
wr_en  in  1  duty write strobe, one cycle
wr_ch  in  4  target channel index
wr_duty  in  DUTY_W  duty value to write
prescale  in  PRESC_W  prescaler divide: tick every prescale+1 clocks
center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at a period boundary
out  out  NUM_CH  registered PWM outputs
period_start  out  1  one-cycle pulse in the cycle the active registers load

Behaviour:
- Reset (rst_n low at a clk edge):
  - Prescaler count, period counter cnt, all shadow and active duty registers, out and period_start clear to 0.
  - Direction register set to up; latched mode set to edge.
  - Reset mid-period aborts the period immediately; no partial pulse is emitted afterwards.
- Prescaler:
  - presc_cnt increments each clk.
  - When presc_cnt >= prescale: tick asserts for that cycle and presc_cnt returns to 0.
  - prescale=0 gives a tick every cycle.
  - If prescale is lowered below the current presc_cnt, the tick fires on the next cycle; there is no wrap-around stall.
- Edge mode:
  - On each tick, cnt increments modulo 2^DUTY_W.
  - Boundary = tick with cnt at all-ones (cnt wraps to 0).
  - Period = 2^DUTY_W ticks.
- Center mode:
  - On tick, cnt counts up 0..max, then down max..0.
  - At max with dir up: dir flips to down and cnt holds for that tick. At 0 with dir down: dir flips to up and cnt holds.
  - Boundary = the tick where dir flips down->up.
  - Period = 2^(DUTY_W+1) ticks.
- At a boundary:
  - Every active duty register loads from its shadow register.
  - center_mode is latched; dir is forced to up.
  - period_start pulses high for exactly one clk.
- Duty writes:
  - wr_en with wr_ch < NUM_CH writes the shadow register.
  - wr_ch >= NUM_CH is ignored.
  - A write in the same cycle as a boundary goes to both shadow and active, so the new value applies to the period just starting.
- Output compare, per channel i, registered with 1-clk latency from cnt:
  - en_out[i]=0: out[i]=0.
  - en_out[i]=1, en_pwm[i]=0: out[i]=1.
  - en_out[i]=1, en_pwm[i]=1: out[i] = (duty==all-ones) ? 1 : (cnt < duty).
  - Consequences: duty 0 = constant low. Edge mode gives duty ticks high per period. Center mode gives 2*duty ticks high, centred on cnt=0.
- en_out and en_pwm are not shadowed; a change takes effect on the next clk.

Optional Feature:
PWM_POLARITY_EN:
- Defined: adds input pol (NUM_CH bits). For channels with en_out[i]=1, out[i] is the compare result XOR pol[i]. Disabled channels still drive 0. pol is applied immediately and is not shadowed.
- Undefined: no pol port; outputs are active-high as described under Behaviour.

Test Plan:
- Reset then idle with en_out=0: out=0 for 1000 clks; period_start pulses every 256 clks (prescale=0, edge, DUTY_W=8).
- Edge mode, prescale=0, ch0 duty 0x80, en_out[0]=en_pwm[0]=1: after the first boundary, out[0] is high for 128 clks and low for 128 clks, repeating.
- Duty 0x00 -> out stays 0 for the full period. Duty 0xFF -> out stays 1. en_pwm=0 -> out=1 regardless of duty.
- Shadow update: write ch3 duty 0x40 mid-period while its active value is 0x20. The current period stays 32 high; the next period is 64 high. A write coinciding with period_start takes effect in that same period.
- prescale=3, center mode, ch1 duty 0x10: period = 2048 clks, out[1] high for 128 clks centred on cnt=0. Changing center_mode mid-period takes effect only after the next period_start.
- Write with wr_ch=15 when NUM_CH=8: no register changes. Reset asserted mid-pulse: out drops to 0 on the next clk and the counters restart from 0.
